// File: rtl/lbist_misr_ora_pkg.sv
// lbist_pkg: shared widths, MISR seed/taps and ORA state encoding for the LBIST loop
package lbist_pkg;
  localparam int LBIST_WIDTH = 8;
  localparam logic [7:0] LBIST_SEED = 8'hFF;
  localparam logic [7:0] LBIST_TAPS = 8'b1011_1000;
  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} ora_state_t;
endpackage

// File: rtl/lbist_misr_ora_if.sv
// lbist_misr_ora_if: response/control bundle between BIST controller, CUT and the ORA
interface lbist_misr_ora_if
  import lbist_pkg::*;
#(
  parameter int WIDTH = LBIST_WIDTH
);
  logic start;
  logic resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] signature;
  logic busy;
  logic done;
  logic pass;
  modport master (
    output start, resp_valid, resp_data, golden,
    input signature, busy, done, pass
  );
  modport slave (
    input start, resp_valid, resp_data, golden,
    output signature, busy, done, pass
  );
endinterface

// File: rtl/lbist_misr_ora_misr_core.sv
// misr_core: multiple-input signature register with x^8+x^6+x^5+x^4+1 feedback
module misr_core
  import lbist_pkg::*;
#(
  parameter int WIDTH = LBIST_WIDTH,
  parameter logic [WIDTH-1:0] SEED = LBIST_SEED,
  parameter logic [WIDTH-1:0] TAPS = LBIST_TAPS
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // shift left, feed the tapped parity into bit 0, fold the response word in
  always_ff @(posedge clk)
    if (reset || load) q <= SEED;
    else if (en) q <= {q[WIDTH-2:0] ^ d[WIDTH-1:1], ^(q & TAPS) ^ d[0]};
endmodule

// File: rtl/lbist_misr_ora.sv
// lbist_misr_ora: compacts CUT responses into a MISR and checks the final signature against golden
module lbist_misr_ora
  import lbist_pkg::*;
#(
  parameter int WIDTH = LBIST_WIDTH,
  parameter logic [WIDTH-1:0] SEED = LBIST_SEED,
  parameter int NUM_PATTERNS = 255
) (
  input logic clk,
  input logic reset,
  lbist_misr_ora_if.slave bus
);
  localparam logic [15:0] LAST = 16'(NUM_PATTERNS - 1);
  ora_state_t state, state_nxt;
  logic [15:0] count;
  logic pass_q;
  logic load, en, last_word;
  assign load = (state == IDLE || state == DONE) && bus.start;
  assign en = state == COMPACT && bus.resp_valid;
  assign last_word = en && count == LAST;
  assign bus.busy = state == COMPACT || state == COMPARE;
  assign bus.done = state == DONE;
  assign bus.pass = pass_q;
  misr_core #(.WIDTH(WIDTH), .SEED(SEED)) u_misr (
    .clk(clk), .reset(reset), .load(load), .en(en), .d(bus.resp_data), .q(bus.signature)
  );
  // next-state: compare takes exactly one cycle, start only acts from idle/done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? COMPACT : IDLE;
      COMPACT: state_nxt = last_word ? COMPARE : COMPACT;
      COMPARE: state_nxt = DONE;
      DONE:    state_nxt = bus.start ? COMPACT : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // state, pattern counter and registered verdict; counter restarts instead of reaching NUM_PATTERNS
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        count <= '0;
        pass_q <= 1'b0;
      end else if (en) count <= last_word ? '0 : count + 16'd1;
      if (state == COMPARE) pass_q <= bus.signature == bus.golden;
    end
endmodule

// File: tb/tb_lbist_misr_ora.sv
// tb_lbist_misr_ora: directed scoreboard bench for the LBIST output response analyser
module tb_lbist_misr_ora;
  typedef struct packed {logic [7:0] sig; logic pass;} exp_t;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  lbist_misr_ora_if #(.WIDTH(8)) ia ();
  lbist_misr_ora_if #(.WIDTH(8)) ib ();
  lbist_misr_ora #(.WIDTH(8), .SEED(8'hFF), .NUM_PATTERNS(1)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
  lbist_misr_ora #(.WIDTH(8), .SEED(8'hFF), .NUM_PATTERNS(2)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin : mon_a
    logic prev = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (ia.done && !prev) begin
        if (qa.size() == 0) chk("a_unexpected_done", 16'd1, 16'd0);
        else begin
          e = qa.pop_front();
          chk("a_sb_sig", 16'(ia.signature), 16'(e.sig));
          chk("a_sb_pass", 16'(ia.pass), 16'(e.pass));
        end
      end
      prev = ia.done;
    end
  end
  initial begin : mon_b
    logic prev = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (ib.done && !prev) begin
        if (qb.size() == 0) chk("b_unexpected_done", 16'd1, 16'd0);
        else begin
          e = qb.pop_front();
          chk("b_sb_sig", 16'(ib.signature), 16'(e.sig));
          chk("b_sb_pass", 16'(ib.pass), 16'(e.pass));
        end
      end
      prev = ib.done;
    end
  end
  task automatic run_b(input logic [7:0] w1, input logic [7:0] g, input logic [7:0] exp_sig,
                       input logic exp_pass, input int gap, input bit noise);
    ib.golden = g;
    ib.start = 1;
    step();
    ib.start = 0;
    chk("b_start_sig", 16'(ib.signature), 16'h00FF);
    chk("b_start_busy", 16'(ib.busy), 16'd1);
    ib.resp_valid = 1;
    ib.resp_data = 8'h00;
    step();
    ib.resp_valid = 0;
    ib.resp_data = 8'hA5;
    chk("b_word0_sig", 16'(ib.signature), 16'h00FE);
    for (int i = 0; i < gap; i++) begin
      ib.start = noise;
      step();
      ib.start = 0;
      chk("b_gap_hold", 16'(ib.signature), 16'h00FE);
    end
    ib.resp_valid = 1;
    ib.resp_data = w1;
    qb.push_back('{sig: exp_sig, pass: exp_pass});
    step();
    ib.resp_valid = noise;
    ib.resp_data = 8'hFF;
    ib.start = noise;
    chk("b_word1_sig", 16'(ib.signature), 16'(exp_sig));
    chk("b_compare_done", 16'(ib.done), 16'd0);
    step();
    ib.resp_valid = 0;
    ib.start = 0;
    chk("b_done", 16'(ib.done), 16'd1);
    chk("b_pass", 16'(ib.pass), 16'(exp_pass));
    chk("b_done_sig", 16'(ib.signature), 16'(exp_sig));
    step();
    chk("b_done_held", 16'(ib.done), 16'd1);
  endtask
  initial begin
    ia.start = 0; ia.resp_valid = 0; ia.resp_data = 0; ia.golden = 0;
    ib.start = 0; ib.resp_valid = 0; ib.resp_data = 0; ib.golden = 0;
    step();
    step();
    reset = 0;
    chk("rst_sig", 16'(ib.signature), 16'h00FF);
    chk("rst_busy", 16'(ib.busy), 16'd0);
    chk("rst_done", 16'(ib.done), 16'd0);
    chk("rst_pass", 16'(ib.pass), 16'd0);
    ia.resp_valid = 1;
    step();
    ia.resp_valid = 0;
    chk("idle_valid_ignored", 16'(ia.signature), 16'h00FF);
    ia.golden = 8'hFE;
    ia.start = 1;
    step();
    ia.start = 0;
    ia.resp_valid = 1;
    ia.resp_data = 8'h00;
    qa.push_back('{sig: 8'hFE, pass: 1'b1});
    step();
    ia.resp_valid = 0;
    chk("a_sig", 16'(ia.signature), 16'h00FE);
    chk("a_compare_busy", 16'(ia.busy), 16'd1);
    chk("a_compare_done", 16'(ia.done), 16'd0);
    step();
    chk("a_done", 16'(ia.done), 16'd1);
    chk("a_pass", 16'(ia.pass), 16'd1);
    chk("a_done_busy", 16'(ia.busy), 16'd0);
    run_b(8'h00, 8'hFC, 8'hFC, 1'b1, 0, 1'b0);
    run_b(8'h01, 8'hFC, 8'hFD, 1'b0, 0, 1'b0);
    run_b(8'h00, 8'hFC, 8'hFC, 1'b1, 3, 1'b0);
    ib.start = 1;
    step();
    ib.start = 0;
    ib.resp_valid = 1;
    ib.resp_data = 8'h00;
    step();
    ib.resp_valid = 0;
    reset = 1;
    step();
    reset = 0;
    chk("midrst_sig", 16'(ib.signature), 16'h00FF);
    chk("midrst_busy", 16'(ib.busy), 16'd0);
    chk("midrst_done", 16'(ib.done), 16'd0);
    run_b(8'h00, 8'hFC, 8'hFC, 1'b1, 0, 1'b0);
    run_b(8'h00, 8'hFC, 8'hFC, 1'b1, 2, 1'b1);
    ib.start = 1;
    step();
    ib.start = 0;
    chk("restart_sig", 16'(ib.signature), 16'h00FF);
    chk("restart_done", 16'(ib.done), 16'd0);
    chk("restart_pass", 16'(ib.pass), 16'd0);
    step();
    step();
    chk("qa_drained", 16'(qa.size()), 16'd0);
    chk("qb_drained", 16'(qb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
